// File: rtl/clock_pkg.sv
// Shared types, BCD limits and BCD helper functions for the clock_hms block.
package clock_pkg;

  // Load-path FSM states
  typedef enum logic [1:0] {
    ST_COUNT = 2'd0,
    ST_CHECK = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  // One packed-BCD time field (two digits)
  typedef logic [7:0] bcd8_t;

  localparam bcd8_t      BCD_MIN_SEC_MAX = 8'h59;
  localparam bcd8_t      BCD_HOUR_MAX    = 8'h23;
  localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;

  // True when both digits are decimal and the field does not exceed lim.
  // With decimal digits, packed BCD orders the same as plain binary.
  function automatic logic bcd_field_ok(input bcd8_t v, input bcd8_t lim);
    logic ok;
    if ((v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX) && (v <= lim)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Next value of a two-digit BCD field that wraps to 00 after max_v
  function automatic bcd8_t bcd_inc(input bcd8_t v, input bcd8_t max_v);
    bcd8_t n;
    if (v == max_v) begin
      n = 8'h00;
    end else if (v[3:0] == BCD_DIGIT_MAX) begin
      n = {v[7:4] + 4'd1, 4'd0};
    end else begin
      n = {v[7:4], v[3:0] + 4'd1};
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping after MAX, with synchronous load and a
// carry that is high in the cycle an increment wraps MAX back to 00.
module bcd_mod_counter import clock_pkg::*; #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       carry
);

  bcd8_t value_r;

  assign value = value_r;
  assign carry = inc & (value_r == MAX);

  // Field register: load has priority, otherwise step on inc
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_r <= 8'h00;
    end else if (load) begin
      value_r <= load_value;
    end else if (inc) begin
      value_r <= bcd_inc(value_r, MAX);
    end else begin
      value_r <= value_r;
    end
  end

endmodule

// File: rtl/clock_hms.sv
// clock_hms: BCD hh:mm:ss time-of-day clock driven by a tick prescaler, with
// a checked two-cycle load path.
// Optional feature: define CLOCK_HMS_ALARM_EN to add the hh:mm alarm
// comparator (ports alarm_hh, alarm_mm, alarm).
module clock_hms import clock_pkg::*; #(
  parameter int TICKS_PER_SEC = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       run,
  input  logic       load_valid,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_ready,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       load_err
`ifdef CLOCK_HMS_ALARM_EN
  ,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  output logic       alarm
`endif
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  state_t        state_r;
  logic          load_ready_r;
  logic          load_err_r;
  logic          load_ok_r;
  bcd8_t         stage_hh_r;
  bcd8_t         stage_mm_r;
  bcd8_t         stage_ss_r;
  logic [PW-1:0] presc_r;
  logic          sec_pulse_r;
  logic          day_wrap_r;

  logic          stage_ok_s;
  logic          apply_s;
  logic          count_tick_s;
  logic          sec_inc_s;
  logic          ss_carry_s;
  logic          mm_carry_s;
  logic          hh_carry_s;
  bcd8_t         hh_s;
  bcd8_t         mm_s;
  bcd8_t         ss_s;

  assign stage_ok_s = bcd_field_ok(stage_hh_r, BCD_HOUR_MAX) &
                      bcd_field_ok(stage_mm_r, BCD_MIN_SEC_MAX) &
                      bcd_field_ok(stage_ss_r, BCD_MIN_SEC_MAX);

  // Only an accepted, checked load writes the time
  assign apply_s = (state_r == ST_APPLY) & load_ok_r;

  // A tick counts only in COUNT with run high and no load being accepted
  assign count_tick_s = (state_r == ST_COUNT) & run & tick & ~load_valid;
  assign sec_inc_s    = count_tick_s & (presc_r == PRESC_MAX);

  // Load FSM: COUNT accepts, CHECK validates, APPLY writes (or discards a
  // rejected load) so load_ready is low for two cycles on either outcome.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_COUNT;
      load_ready_r <= 1'b1;
      load_err_r   <= 1'b0;
      load_ok_r    <= 1'b0;
      stage_hh_r   <= 8'h00;
      stage_mm_r   <= 8'h00;
      stage_ss_r   <= 8'h00;
    end else begin
      case (state_r)
        ST_COUNT: begin
          load_err_r <= 1'b0;
          load_ok_r  <= 1'b0;
          if (load_valid) begin
            stage_hh_r   <= load_hh;
            stage_mm_r   <= load_mm;
            stage_ss_r   <= load_ss;
            state_r      <= ST_CHECK;
            load_ready_r <= 1'b0;
          end else begin
            state_r      <= ST_COUNT;
            load_ready_r <= 1'b1;
          end
        end
        ST_CHECK: begin
          load_ok_r    <= stage_ok_s;
          load_err_r   <= ~stage_ok_s;
          state_r      <= ST_APPLY;
          load_ready_r <= 1'b0;
        end
        ST_APPLY: begin
          load_ok_r    <= 1'b0;
          load_err_r   <= 1'b0;
          state_r      <= ST_COUNT;
          load_ready_r <= 1'b1;
        end
        default: begin
          load_ok_r    <= 1'b0;
          load_err_r   <= 1'b0;
          state_r      <= ST_COUNT;
          load_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Tick prescaler: cleared by a load, wraps after TICKS_PER_SEC ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r <= '0;
    end else if (apply_s) begin
      presc_r <= '0;
    end else if (count_tick_s) begin
      if (presc_r == PRESC_MAX) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  bcd_mod_counter #(.MAX(BCD_MIN_SEC_MAX)) u_ss (
    .clk        (clk),
    .reset      (reset),
    .inc        (sec_inc_s),
    .load       (apply_s),
    .load_value (stage_ss_r),
    .value      (ss_s),
    .carry      (ss_carry_s)
  );

  bcd_mod_counter #(.MAX(BCD_MIN_SEC_MAX)) u_mm (
    .clk        (clk),
    .reset      (reset),
    .inc        (ss_carry_s),
    .load       (apply_s),
    .load_value (stage_mm_r),
    .value      (mm_s),
    .carry      (mm_carry_s)
  );

  bcd_mod_counter #(.MAX(BCD_HOUR_MAX)) u_hh (
    .clk        (clk),
    .reset      (reset),
    .inc        (mm_carry_s),
    .load       (apply_s),
    .load_value (stage_hh_r),
    .value      (hh_s),
    .carry      (hh_carry_s)
  );

  // Event pulses, aligned with the cycle the new time becomes visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_pulse_r <= 1'b0;
      day_wrap_r  <= 1'b0;
    end else begin
      sec_pulse_r <= sec_inc_s;
      day_wrap_r  <= hh_carry_s;
    end
  end

`ifdef CLOCK_HMS_ALARM_EN
  bcd8_t next_mm_s;
  bcd8_t next_hh_s;
  logic  alarm_r;

  // Time the counters will hold after this cycle's carry chain
  always_comb begin
    next_mm_s = mm_s;
    next_hh_s = hh_s;
    if (ss_carry_s) begin
      next_mm_s = bcd_inc(mm_s, BCD_MIN_SEC_MAX);
    end else begin
      next_mm_s = mm_s;
    end
    if (mm_carry_s) begin
      next_hh_s = bcd_inc(hh_s, BCD_HOUR_MAX);
    end else begin
      next_hh_s = hh_s;
    end
  end

  // Alarm fires only when counting rolls the time onto alarm_hh:alarm_mm:00
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_r <= 1'b0;
    end else begin
      alarm_r <= ss_carry_s & (next_mm_s == alarm_mm) & (next_hh_s == alarm_hh);
    end
  end

  assign alarm = alarm_r;
`else
  // Alarm comparator not built in this configuration
`endif

  assign load_ready = load_ready_r;
  assign hh         = hh_s;
  assign mm         = mm_s;
  assign ss         = ss_s;
  assign sec_pulse  = sec_pulse_r;
  assign day_wrap   = day_wrap_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_clock_hms.sv
// Self-checking bench for clock_hms: directed scenarios plus randomized
// stimulus, all compared against a seconds-of-day reference model.
module tb_clock_hms;

  localparam int TPS = 1000;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       run;
  logic       load_valid;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       load_ready;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       sec_pulse;
  logic       day_wrap;
  logic       load_err;
`ifdef CLOCK_HMS_ALARM_EN
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic       alarm;
`endif

  int n_checks;
  int n_fail;

  // reference model state
  int         m_secs;
  int         m_presc;
  int         m_busy;
  bit         m_ok;
  logic [7:0] m_sh, m_sm, m_ss;
  bit         e_sec, e_wrap, e_err, e_alarm;

  clock_hms #(.TICKS_PER_SEC(TPS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .run        (run),
    .load_valid (load_valid),
    .load_hh    (load_hh),
    .load_mm    (load_mm),
    .load_ss    (load_ss),
    .load_ready (load_ready),
    .hh         (hh),
    .mm         (mm),
    .ss         (ss),
    .sec_pulse  (sec_pulse),
    .day_wrap   (day_wrap),
    .load_err   (load_err)
`ifdef CLOCK_HMS_ALARM_EN
    ,
    .alarm_hh   (alarm_hh),
    .alarm_mm   (alarm_mm),
    .alarm      (alarm)
`endif
  );

  // free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic bit field_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd2int(v) <= lim);
  endfunction

  function automatic void m_reset();
    m_secs = 0; m_presc = 0; m_busy = 0; m_ok = 1'b0;
    m_sh = 8'h00; m_sm = 8'h00; m_ss = 8'h00;
    e_sec = 1'b0; e_wrap = 1'b0; e_err = 1'b0; e_alarm = 1'b0;
  endfunction

  // one clock edge of the reference model
  function automatic void model_step(input logic t, input logic r, input logic lv,
                                     input logic [7:0] lh, input logic [7:0] lm,
                                     input logic [7:0] ls);
    e_sec = 1'b0; e_wrap = 1'b0; e_err = 1'b0; e_alarm = 1'b0;
    if (m_busy == 0) begin
      if (lv) begin
        m_sh = lh; m_sm = lm; m_ss = ls;
        m_busy = 2;
      end else if (r && t) begin
        m_presc++;
        if (m_presc == TPS) begin
          m_presc = 0;
          m_secs = (m_secs + 1) % 86400;
          e_sec = 1'b1;
          e_wrap = (m_secs == 0);
`ifdef CLOCK_HMS_ALARM_EN
          e_alarm = (m_secs == bcd2int(alarm_hh) * 3600 + bcd2int(alarm_mm) * 60);
`endif
        end
      end
    end else if (m_busy == 2) begin
      m_busy = 1;
      m_ok = field_ok(m_sh, 23) && field_ok(m_sm, 59) && field_ok(m_ss, 59);
      e_err = !m_ok;
    end else begin
      m_busy = 0;
      if (m_ok) begin
        m_secs = bcd2int(m_sh) * 3600 + bcd2int(m_sm) * 60 + bcd2int(m_ss);
        m_presc = 0;
      end
    end
  endfunction

  task automatic compare_all();
    chk("hh", 32'(hh), 32'(int2bcd(m_secs / 3600)));
    chk("mm", 32'(mm), 32'(int2bcd((m_secs / 60) % 60)));
    chk("ss", 32'(ss), 32'(int2bcd(m_secs % 60)));
    chk("load_ready", 32'(load_ready), 32'(m_busy == 0));
    chk("sec_pulse", 32'(sec_pulse), 32'(e_sec));
    chk("day_wrap", 32'(day_wrap), 32'(e_wrap));
    chk("load_err", 32'(load_err), 32'(e_err));
`ifdef CLOCK_HMS_ALARM_EN
    chk("alarm", 32'(alarm), 32'(e_alarm));
`endif
  endtask

  task automatic step(input logic t, input logic r, input logic lv,
                      input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
    tick = t; run = r; load_valid = lv;
    load_hh = lh; load_mm = lm; load_ss = ls;
    @(posedge clk);
    model_step(t, r, lv, lh, lm, ls);
    #1;
    compare_all();
    tick = 1'b0; load_valid = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
    step(1'b0, 1'b1, 1'b1, lh, lm, ls);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic ticks(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, r, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  // reject an invalid load and measure the busy window around it
  task automatic bad_load(input string tag, input logic [7:0] lh, input logic [7:0] lm,
                          input logic [7:0] ls);
    int lows, errs;
    logic [7:0] h0, m0, s0;
    h0 = hh; m0 = mm; s0 = ss;
    lows = 0; errs = 0;
    step(1'b0, 1'b1, 1'b1, lh, lm, ls);
    if (!load_ready) lows++;
    if (load_err) errs++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      if (!load_ready) lows++;
      if (load_err) errs++;
    end
    chk({tag, "_ready_low"}, 32'(lows), 32'd2);
    chk({tag, "_errs"}, 32'(errs), 32'd1);
    chk({tag, "_time"}, {8'h00, hh, mm, ss}, {8'h00, h0, m0, s0});
  endtask

  initial begin
    int pulses;
    int alarms;
    int mode;
    n_checks = 0; n_fail = 0;
    tick = 1'b0; run = 1'b1; load_valid = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00;
`ifdef CLOCK_HMS_ALARM_EN
    alarm_hh = 8'h00; alarm_mm = 8'h01;
`endif
    m_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // async reset mid-count at 12:34:56
    do_load(8'h12, 8'h34, 8'h56);
    chk("load_1234", {8'h00, hh, mm, ss}, 32'h00123456);
    ticks(500, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_time", {8'h00, hh, mm, ss}, 32'h0);
    chk("rst_async_ready", 32'(load_ready), 32'd1);
    chk("rst_async_pulses", 32'({sec_pulse, day_wrap, load_err}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    compare_all();

    // first second boundary
    pulses = 0;
    for (int i = 0; i < TPS - 1; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      if (sec_pulse) pulses++;
    end
    chk("999_ticks_ss", 32'(ss), 32'h00);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    if (sec_pulse) pulses++;
    chk("1000_ticks_ss", 32'(ss), 32'h01);
    chk("1000_ticks_pulses", 32'(pulses), 32'd1);

    // day rollover
    do_load(8'h23, 8'h59, 8'h59);
    ticks(TPS - 1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("wrap_time", {8'h00, hh, mm, ss}, 32'h0);
    chk("wrap_pulses", 32'({sec_pulse, day_wrap}), 32'd3);

    // rejected loads
    bad_load("bad_hh", 8'h24, 8'h00, 8'h00);
    bad_load("bad_ss", 8'h00, 8'h00, 8'h5A);

    // load coinciding with the tick that would end a second
    do_load(8'h05, 8'h06, 8'h07);
    ticks(TPS - 1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 8'h10, 8'h20, 8'h30);
    chk("drop_tick_ss", 32'({sec_pulse, ss}), 32'h007);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("drop_tick_wait", {8'h00, hh, mm, ss}, 32'h00050607);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("drop_tick_load", {8'h00, hh, mm, ss}, 32'h00102030);
    ticks(TPS - 1, 1'b1);
    chk("presc_clear_999", 32'(ss), 32'h30);
    ticks(1, 1'b1);
    chk("presc_clear_1000", 32'(ss), 32'h31);

    // run low freezes time, loads still accepted
    ticks(3 * TPS, 1'b0);
    chk("frozen", {8'h00, hh, mm, ss}, 32'h00102031);
    step(1'b0, 1'b0, 1'b1, 8'h08, 8'h09, 8'h10);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("load_run0", {8'h00, hh, mm, ss}, 32'h00080910);

`ifdef CLOCK_HMS_ALARM_EN
    do_load(8'h00, 8'h00, 8'h59);
    alarms = 0;
    for (int i = 0; i < TPS; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      if (alarm) alarms++;
    end
    chk("alarm_time", {8'h00, hh, mm, ss}, 32'h00000100);
    chk("alarm_count", 32'(alarms), 32'd1);
    chk("alarm_now", 32'(alarm), 32'd1);
    do_load(8'h00, 8'h01, 8'h00);
    chk("alarm_not_on_load", 32'(alarm), 32'd0);
`else
    alarms = 0;
`endif

    // randomized traffic near interesting boundaries
    do_load(8'h23, 8'h58, 8'h58);
    for (int i = 0; i < 6000; i++) begin
      logic t, r, lv;
      logic [7:0] lh, lm, ls;
      t  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 15) != 0);
      lv = (m_busy == 0) && ($urandom_range(0, 299) == 0);
      mode = $urandom_range(0, 3);
      lh = 8'($urandom); lm = 8'($urandom); ls = 8'($urandom);
      if (mode == 1) begin
        lh = 8'h23; lm = 8'h59; ls = int2bcd($urandom_range(55, 59));
      end else if (mode == 2) begin
        lh = int2bcd($urandom_range(0, 23));
        lm = int2bcd($urandom_range(0, 59));
        ls = int2bcd($urandom_range(0, 59));
      end else if (mode == 3) begin
        lh = int2bcd($urandom_range(0, 23));
        lm = int2bcd($urandom_range(0, 59));
        ls = {4'(int'($urandom_range(0, 5))), 4'(int'($urandom_range(10, 15)))};
      end
      step(t, r, lv, lh, lm, ls);
    end

    // reset while a load is being checked leaves no partial time
    step(1'b0, 1'b1, 1'b1, 8'h11, 8'h22, 8'h33);
    #2 reset = 1'b1;
    #1;
    chk("rst_in_check", {8'h00, hh, mm, ss}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_reset();
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("rst_abort_load", {8'h00, hh, mm, ss}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
